// File: rtl/pattern_selector_pkg.sv
// Shared types and helpers for the pattern selector: rail sequencer states and
// a width helper for sizing the millisecond counters.
package pattern_selector_pkg;

  typedef enum logic [1:0] {
    RAIL_OFF  = 2'd0,
    RAIL_UP   = 2'd1,
    RAIL_ON   = 2'd2,
    RAIL_DOWN = 2'd3
  } rail_state_e;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while (((32'd1 << w) < value) && (w < 31)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pattern_selector_key_filter.sv
// One panel key: synchroniser, ms-tick debounce and hold/auto-repeat timing.
// step_o pulses once per accepted press and once per repeat interval.
module key_filter
  import pattern_selector_pkg::*;
#(
  parameter int unsigned DEB_MS  = 20,
  parameter int unsigned HOLD_MS = 500,
  parameter int unsigned RPT_MS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms_i,
  input  logic key_n_i,
  input  logic clr_rpt_i,
  output logic step_o,
  output logic held_o
);

  localparam int unsigned DEB_W   = clog2(DEB_MS + 1);
  localparam int unsigned TMR_MAX = (HOLD_MS > RPT_MS) ? HOLD_MS : RPT_MS;
  localparam int unsigned TMR_W   = clog2(TMR_MAX + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_MS - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_MS - 1);
  localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(RPT_MS - 1);

  logic [1:0]       sync_q;
  logic             key_lvl_c;
  logic             press_q, press_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rpt_en_q, rpt_en_d;
  logic             hold_ph_q, hold_ph_d;
  logic             step_q, step_d;

  assign key_lvl_c = ~sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      press_q   <= 1'b0;
      deb_q     <= '0;
      tmr_q     <= '0;
      rpt_en_q  <= 1'b0;
      hold_ph_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      press_q   <= press_d;
      deb_q     <= deb_d;
      tmr_q     <= tmr_d;
      rpt_en_q  <= rpt_en_d;
      hold_ph_q <= hold_ph_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    press_d   = press_q;
    deb_d     = deb_q;
    tmr_d     = tmr_q;
    rpt_en_d  = rpt_en_q;
    hold_ph_d = hold_ph_q;
    step_d    = 1'b0;

    // Filtered level follows the key only after DEB_MS consecutive mismatching ticks.
    if (key_lvl_c == press_q) begin
      deb_d = '0;
    end else if (tick_ms_i) begin
      if (deb_q == DEB_LAST) begin
        press_d = key_lvl_c;
        deb_d   = '0;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end

    if (!press_q && press_d) begin
      step_d    = 1'b1;
      rpt_en_d  = 1'b1;
      hold_ph_d = 1'b1;
      tmr_d     = '0;
    end else if (!press_d) begin
      rpt_en_d = 1'b0;
    end else if (rpt_en_q && tick_ms_i) begin
      if (tmr_q == (hold_ph_q ? HOLD_LAST : RPT_LAST)) begin
        step_d    = 1'b1;
        hold_ph_d = 1'b0;
        tmr_d     = '0;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end

    // A suppressed key stays silent until it is released and pressed again.
    if (clr_rpt_i) rpt_en_d = 1'b0;
  end

  assign step_o = step_q;
  assign held_o = press_q;

endmodule

// File: rtl/pattern_selector.sv
// Panel pattern selector: ms prescaler, two debounced keys stepping dis_sn,
// and an N_RAIL supply-enable sequencer that gates key steps.
module pattern_selector
  import pattern_selector_pkg::*;
#(
  parameter int unsigned CLK_PER_MS  = 81000,
  parameter int unsigned DEB_MS      = 20,
  parameter int unsigned HOLD_MS     = 500,
  parameter int unsigned RPT_MS      = 100,
  parameter int unsigned SN_W        = 8,
  parameter int unsigned PAT_MIN     = 127,
  parameter int unsigned PAT_MAX     = 255,
  parameter int unsigned WRAP        = 0,
  parameter int unsigned N_RAIL      = 4,
  parameter int unsigned RAIL_GAP_MS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_up,
  input  logic              sw_down,
  input  logic              lock,
  input  logic              pwr_req,
  output logic [N_RAIL-1:0] en_rail,
  output logic              rail_on,
  output logic [SN_W-1:0]   dis_sn,
  output logic              dis_chg
);

  localparam int unsigned PRE_W = clog2(CLK_PER_MS);
  localparam int unsigned GAP_W = clog2(RAIL_GAP_MS + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_PER_MS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(RAIL_GAP_MS - 1);
  localparam logic [SN_W-1:0]   SN_MIN     = SN_W'(PAT_MIN);
  localparam logic [SN_W-1:0]   SN_MAX     = SN_W'(PAT_MAX);
  localparam logic [N_RAIL-1:0] RAIL_FIRST = N_RAIL'(1);
  localparam logic [N_RAIL-1:0] RAIL_ALL   = '1;

  logic [PRE_W-1:0]  pre_q;
  logic              tick_c;
  logic              step_up, step_dn, held_up, held_dn;
  logic              accept_c, both_c, clr_rpt_c;
  logic [SN_W-1:0]   sn_q, sn_d;
  logic              chg_q, chg_d;
  rail_state_e       state_q, state_d;
  logic [N_RAIL-1:0] rail_q, rail_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              rail_on_q, rail_on_d;

  assign tick_c = (pre_q == PRE_LAST);

  key_filter #(.DEB_MS(DEB_MS), .HOLD_MS(HOLD_MS), .RPT_MS(RPT_MS)) u_key_up (
    .clk(clk), .rst(rst), .tick_ms_i(tick_c), .key_n_i(sw_up),
    .clr_rpt_i(clr_rpt_c), .step_o(step_up), .held_o(held_up)
  );

  key_filter #(.DEB_MS(DEB_MS), .HOLD_MS(HOLD_MS), .RPT_MS(RPT_MS)) u_key_dn (
    .clk(clk), .rst(rst), .tick_ms_i(tick_c), .key_n_i(sw_down),
    .clr_rpt_i(clr_rpt_c), .step_o(step_dn), .held_o(held_dn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      sn_q      <= SN_MIN;
      chg_q     <= 1'b0;
      state_q   <= RAIL_OFF;
      rail_q    <= '0;
      gap_q     <= '0;
      rail_on_q <= 1'b0;
    end else begin
      pre_q     <= tick_c ? '0 : pre_q + PRE_W'(1);
      sn_q      <= sn_d;
      chg_q     <= chg_d;
      state_q   <= state_d;
      rail_q    <= rail_d;
      gap_q     <= gap_d;
      rail_on_q <= rail_on_d;
    end
  end

  // Step arbitration; any step seen with both keys down collapses to PAT_MIN.
  always_comb begin
    accept_c  = ~lock & (state_q == RAIL_ON);
    both_c    = (step_up | step_dn) & held_up & held_dn;
    clr_rpt_c = both_c | ~accept_c;
    sn_d      = sn_q;
    if (accept_c) begin
      if (both_c) begin
        sn_d = SN_MIN;
      end else if (step_up) begin
        sn_d = (sn_q == SN_MAX) ? ((WRAP != 0) ? SN_MIN : SN_MAX) : sn_q + SN_W'(1);
      end else if (step_dn) begin
        sn_d = (sn_q == SN_MIN) ? ((WRAP != 0) ? SN_MAX : SN_MIN) : sn_q - SN_W'(1);
      end
    end
    chg_d = (sn_d != sn_q);
  end

  // Rail sequencer: thermometer-coded enables, one bit per gap.
  always_comb begin
    state_d   = state_q;
    rail_d    = rail_q;
    gap_d     = gap_q;
    rail_on_d = rail_on_q;
    case (state_q)
      RAIL_OFF: begin
        if (pwr_req) begin
          rail_d  = RAIL_FIRST;
          gap_d   = '0;
          state_d = RAIL_UP;
          if (rail_d == RAIL_ALL) begin
            state_d   = RAIL_ON;
            rail_on_d = 1'b1;
          end
        end
      end
      RAIL_UP: begin
        if (!pwr_req) begin
          rail_d  = rail_q >> 1;
          gap_d   = '0;
          state_d = (rail_d == '0) ? RAIL_OFF : RAIL_DOWN;
        end else if (tick_c) begin
          if (gap_q == GAP_LAST) begin
            rail_d = (rail_q << 1) | RAIL_FIRST;
            gap_d  = '0;
            if (rail_d == RAIL_ALL) begin
              state_d   = RAIL_ON;
              rail_on_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      RAIL_ON: begin
        if (!pwr_req) begin
          rail_d    = rail_q >> 1;
          gap_d     = '0;
          rail_on_d = 1'b0;
          state_d   = (rail_d == '0) ? RAIL_OFF : RAIL_DOWN;
        end
      end
      RAIL_DOWN: begin
        if (pwr_req) begin
          gap_d   = '0;
          state_d = RAIL_UP;
        end else if (tick_c) begin
          if (gap_q == GAP_LAST) begin
            rail_d = rail_q >> 1;
            gap_d  = '0;
            if (rail_d == '0) state_d = RAIL_OFF;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = RAIL_OFF;
    endcase
  end

  assign en_rail = rail_q;
  assign rail_on = rail_on_q;
  assign dis_sn  = sn_q;
  assign dis_chg = chg_q;

endmodule

// File: tb/tb_pattern_selector.sv
// Scoreboard bench for pattern_selector: a saturating and a wrapping instance
// share stimulus; expected pattern numbers and rail steps come from a ms-level model.
module tb_pattern_selector;

  localparam int K_UP   = 0;
  localparam int K_DN   = 1;
  localparam int K_BOTH = 2;
  localparam int PMIN   = 127;
  localparam int PMAX   = 255;

  logic clk = 1'b0;
  logic rst, sw_up, sw_down, lock, pwr_req;
  logic [3:0] en_rail0, en_rail1;
  logic       rail_on0, rail_on1;
  logic [7:0] dis_sn0, dis_sn1;
  logic       dis_chg0, dis_chg1;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int sn_m[2];
  bit rails_on_m;
  int q0[$];
  int q1[$];
  int rq[$];
  int chg_t[$];
  int rail_t[$];
  logic [3:0] prev_rail = 4'd0;
  int rail_e;
  int t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_selector #(
    .CLK_PER_MS(10), .DEB_MS(2), .HOLD_MS(10), .RPT_MS(4), .SN_W(8),
    .PAT_MIN(127), .PAT_MAX(255), .WRAP(0), .N_RAIL(4), .RAIL_GAP_MS(3)
  ) dut0 (
    .clk(clk), .rst(rst), .sw_up(sw_up), .sw_down(sw_down), .lock(lock),
    .pwr_req(pwr_req), .en_rail(en_rail0), .rail_on(rail_on0),
    .dis_sn(dis_sn0), .dis_chg(dis_chg0)
  );

  pattern_selector #(
    .CLK_PER_MS(10), .DEB_MS(2), .HOLD_MS(10), .RPT_MS(4), .SN_W(8),
    .PAT_MIN(127), .PAT_MAX(255), .WRAP(1), .N_RAIL(4), .RAIL_GAP_MS(3)
  ) dut1 (
    .clk(clk), .rst(rst), .sw_up(sw_up), .sw_down(sw_down), .lock(lock),
    .pwr_req(pwr_req), .en_rail(en_rail1), .rail_on(rail_on1),
    .dis_sn(dis_sn1), .dis_chg(dis_chg1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nxt(input int kind, input int v, input bit w);
    if (kind == K_BOTH) return PMIN;
    if (kind == K_UP) return (v == PMAX) ? (w ? PMIN : PMAX) : v + 1;
    return (v == PMIN) ? (w ? PMAX : PMIN) : v - 1;
  endfunction

  task automatic model_apply(input int kind, input int cnt);
    int nv;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < cnt; k++) begin
        nv = nxt(kind, sn_m[i], i == 1);
        if (nv != sn_m[i]) begin
          if (i == 0) q0.push_back(nv);
          else q1.push_back(nv);
        end
        sn_m[i] = nv;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle();
    chk("sb_pending0", q0.size(), 0);
    chk("sb_pending1", q1.size(), 0);
    chk("dis_sn0_model", int'(dis_sn0), sn_m[0]);
    chk("dis_sn1_model", int'(dis_sn1), sn_m[1]);
    q0.delete();
    q1.delete();
  endtask

  // Hold lengths sit mid-way between repeat instants so debounce jitter cannot move the count.
  task automatic press(input int kind, input int n_rpt, input bit bounce);
    int   hold;
    logic lvl;
    hold = (kind == K_BOTH) ? 200 : ((n_rpt == 0) ? 50 : 80 + 40 * n_rpt);
    if (rails_on_m && !lock) model_apply(kind, (kind == K_BOTH) ? 1 : n_rpt + 1);
    for (int c = 0; c < hold; c++) begin
      lvl = (bounce && c < 5 && (c % 2 == 1)) ? 1'b1 : 1'b0;
      if (kind != K_DN) sw_up = lvl;
      if (kind != K_UP) sw_down = lvl;
      cycles(1);
    end
    sw_up = 1'b1;
    sw_down = 1'b1;
    cycles(60);
    check_idle();
  endtask

  task automatic wait_rails();
    for (int c = 0; c < 400; c++) begin
      if (rq.size() == 0) break;
      cycles(1);
    end
    chk("rail_seq_done", rq.size(), 0);
    rq.delete();
  endtask

  // Monitor: pops the scoreboards whenever a DUT presents a change.
  always @(negedge clk) begin
    if (dis_chg0) begin
      if (q0.size() == 0) chk("unexpected_chg0", int'(dis_chg0), 0);
      else chk("dis_sn0", int'(dis_sn0), q0.pop_front());
      chg_t.push_back(cyc);
    end
    if (dis_chg1) begin
      if (q1.size() == 0) chk("unexpected_chg1", int'(dis_chg1), 0);
      else chk("dis_sn1", int'(dis_sn1), q1.pop_front());
    end
    if (en_rail0 != prev_rail) begin
      if (rq.size() == 0) begin
        chk("unexpected_rail", int'(en_rail0), int'(prev_rail));
      end else begin
        rail_e = rq.pop_front();
        chk("en_rail0", int'(en_rail0), rail_e);
        chk("en_rail1", int'(en_rail1), rail_e);
        chk("rail_on0", int'(rail_on0), int'(rail_e == 15));
        chk("rail_on1", int'(rail_on1), int'(rail_e == 15));
      end
      rail_t.push_back(cyc);
      prev_rail = en_rail0;
    end
  end

  initial begin
    rst = 1'b1; sw_up = 1'b1; sw_down = 1'b1; lock = 1'b0; pwr_req = 1'b0;
    sn_m[0] = PMIN; sn_m[1] = PMIN; rails_on_m = 1'b0;
    cycles(3);
    chk("rst_en_rail0", int'(en_rail0), 0);
    chk("rst_rail_on0", int'(rail_on0), 0);
    chk("rst_dis_sn0", int'(dis_sn0), PMIN);
    chk("rst_dis_chg0", int'(dis_chg0), 0);
    chk("rst_dis_sn1", int'(dis_sn1), PMIN);
    rst = 1'b0;
    cycles(2);

    // Power-up ramp
    rail_t.delete();
    rq.push_back(1); rq.push_back(3); rq.push_back(7); rq.push_back(15);
    pwr_req = 1'b1;
    wait_rails();
    chk("up_steps", rail_t.size(), 4);
    if (rail_t.size() == 4) begin
      chk("up_gap1_in_range", int'(rail_t[1] - rail_t[0] >= 21 && rail_t[1] - rail_t[0] <= 30), 1);
      chk("up_gap2", rail_t[2] - rail_t[1], 30);
      chk("up_gap3", rail_t[3] - rail_t[2], 30);
    end
    rails_on_m = 1'b1;
    check_idle();

    // Bouncy press with auto-repeat
    chg_t.delete();
    press(K_UP, 6, 1'b1);
    chk("rpt_step_count", chg_t.size(), 7);
    if (chg_t.size() == 7) begin
      chk("rpt_first", chg_t[1] - chg_t[0], 100);
      for (int i = 2; i < 7; i++) chk("rpt_period", chg_t[i] - chg_t[i-1], 40);
    end

    // Long hold into the top end, then a press at the top
    press(K_UP, 125, 1'b0);
    chk("sat_at_max", int'(dis_sn0), PMAX);
    press(K_UP, 0, 1'b0);
    press(K_BOTH, 0, 1'b0);
    chk("both_to_min", int'(dis_sn1), PMIN);
    press(K_DN, 0, 1'b0);
    chk("wrap_down", int'(dis_sn1), PMAX);

    // Key held across lock/unlock is ignored until re-pressed
    lock = 1'b1;
    sw_up = 1'b0;
    cycles(60);
    lock = 1'b0;
    cycles(240);
    sw_up = 1'b1;
    cycles(60);
    check_idle();
    press(K_UP, 0, 1'b0);
    chk("repress_after_lock", int'(dis_sn0), 128);

    for (int it = 0; it < 16; it++) begin
      int k;
      lock = ($urandom_range(0, 3) == 0);
      cycles(1);
      k = $urandom_range(0, 4);
      press((k < 2) ? K_UP : ((k < 4) ? K_DN : K_BOTH), $urandom_range(0, 3), 1'b0);
    end
    lock = 1'b0;
    cycles(2);

    // Full ramp-down, re-ramp to 0111, then drop mid-ramp with a key press
    rails_on_m = 1'b0;
    rq.push_back(7); rq.push_back(3); rq.push_back(1); rq.push_back(0);
    pwr_req = 1'b0;
    wait_rails();
    rq.push_back(1); rq.push_back(3); rq.push_back(7);
    pwr_req = 1'b1;
    wait_rails();
    rail_t.delete();
    t0 = cyc;
    rq.push_back(3); rq.push_back(1); rq.push_back(0);
    pwr_req = 1'b0;
    press(K_UP, 0, 1'b0);
    wait_rails();
    chk("down_steps", rail_t.size(), 3);
    if (rail_t.size() == 3) begin
      chk("down_first_immediate", rail_t[0] - t0, 1);
      chk("down_gap1_in_range", int'(rail_t[1] - rail_t[0] >= 21 && rail_t[1] - rail_t[0] <= 30), 1);
      chk("down_gap2", rail_t[2] - rail_t[1], 30);
    end

    // Reset in the middle of a ramp
    rq.push_back(1); rq.push_back(3);
    pwr_req = 1'b1;
    wait_rails();
    rq.push_back(0);
    rst = 1'b1;
    pwr_req = 1'b0;
    cycles(1);
    chk("midrst_en_rail0", int'(en_rail0), 0);
    chk("midrst_en_rail1", int'(en_rail1), 0);
    chk("midrst_dis_sn0", int'(dis_sn0), PMIN);
    chk("midrst_dis_sn1", int'(dis_sn1), PMIN);
    chk("midrst_rail_on0", int'(rail_on0), 0);
    rst = 1'b0;
    sn_m[0] = PMIN; sn_m[1] = PMIN;
    cycles(20);
    chk("rail_pending", rq.size(), 0);
    check_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
